// File: rtl/ref_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// ref_ramp_ctrl : slews the servo reference toward a latched target in
//                 bounded steps, one step per tick. Optional clamp: REF_CLAMP_EN
// Revision 1.0
// ============================================================================
module ref_ramp_ctrl #(
    parameter int TICK_DIV = 50000,
    parameter int STEP     = 1,
    parameter int REF_MIN  = 0,
    parameter int REF_MAX  = 180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enviar,
    input  logic        hold,
    input  logic [7:0]  ref_in,
    output logic [19:0] ref_out,
    output logic [7:0]  ref_cur,
    output logic [7:0]  target,
    output logic        busy,
    output logic        done
);

    localparam int                 CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [8:0]         STEP_W   = 9'(STEP);
    localparam logic [7:0]         STEP_B   = 8'(STEP);

    if (TICK_DIV < 1 || STEP < 1 || STEP > 255 || REF_MIN > REF_MAX) begin : g_bad_cfg
        $error("ref_ramp_ctrl: invalid parameter set");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sync_q, sync_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         cur_q, cur_d;
    logic [7:0]         tgt_q, tgt_d;
    logic               pend_q, pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               send_p;
    logic               go;
    logic               tick;
    logic [8:0]         diff;
    logic [7:0]         ref_new;

    assign sync_d = {sync_q[1:0], enviar};
    assign send_p = sync_q[1] & ~sync_q[2];

`ifdef REF_CLAMP_EN
    always_comb begin
        ref_new = ref_in;
        if (int'(ref_in) < REF_MIN) begin
            ref_new = 8'(REF_MIN);
        end else if (int'(ref_in) > REF_MAX) begin
            ref_new = 8'(REF_MAX);
        end
    end
`else
    assign ref_new = ref_in;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        pend_d  = 1'b0;
        tick    = 1'b0;
        diff    = 9'd0;
        go      = send_p | pend_q;

        case (state_q)
            IDLE: begin
                if (go) begin
                    tgt_d   = ref_new;
                    cnt_d   = '0;
                    state_d = (ref_new == cur_q) ? DONE : RAMP;
                end
            end
            RAMP: begin
                tick = ~hold & (cnt_q == CNT_LAST);
                if (!hold) begin
                    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
                end
                if (tick) begin
                    diff = (tgt_q >= cur_q) ? ({1'b0, tgt_q} - {1'b0, cur_q})
                                            : ({1'b0, cur_q} - {1'b0, tgt_q});
                    if (diff <= STEP_W) begin
                        cur_d   = tgt_q;
                        state_d = DONE;
                    end else if (tgt_q > cur_q) begin
                        cur_d = cur_q + STEP_B;
                    end else begin
                        cur_d = cur_q - STEP_B;
                    end
                end
                // A retarget sees the post-tick reference, so a coinciding tick is never lost
                if (send_p) begin
                    tgt_d   = ref_new;
                    state_d = (ref_new == cur_d) ? DONE : RAMP;
                end
            end
            DONE: begin
                state_d = IDLE;
                pend_d  = send_p;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RAMP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sync_q  <= 3'b000;
            cnt_q   <= '0;
            cur_q   <= 8'd0;
            tgt_q   <= 8'd0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ref_out = {12'b0, cur_q};
    assign ref_cur = cur_q;
    assign target  = tgt_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: doc/ref_ramp_ctrl.md
Name: ref_ramp_ctrl

Overview:
- Sequences the servo reference register.
- On an `enviar` request, latches a new 8-bit target from `ref_in` and slews the applied reference toward it in bounded steps, one step per tick period. This keeps the servo loop from seeing step changes.
- Drives the 20-bit reference bus to the servo datapath and exposes current/target values to the BCD/seven-segment display path.

Parameters:
- TICK_DIV, 50000: clock cycles per ramp step (≥1).
- STEP, 1: reference increment per tick (1..255).
- REF_MIN, 0: lower clamp bound, used only with REF_CLAMP_EN.
- REF_MAX, 180: upper clamp bound, used only with REF_CLAMP_EN (REF_MIN ≤ REF_MAX).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-low reset.
- enviar  input  1  send request; level from button/switch, asynchronous to clk.
- hold  input  1  synchronous; freezes the ramp while high.
- ref_in  input  8  requested reference.
- ref_out  output  20  applied reference: {12'b0, ref_cur}.
- ref_cur  output  8  current applied reference (to real-value display).
- target  output  8  latched target (to chosen-value display).
- busy  output  1  high while ramping.
- done  output  1  one-cycle pulse when ref_cur reaches target.

Behaviour:
- Reset (rst=0, asynchronous):
  - ref_cur=0, target=0, busy=0, done=0.
  - Tick counter=0, synchronizer flops=0, state=IDLE.
  - Applies immediately, including mid-ramp.
- enviar conditioning:
  - 2-FF synchronizer plus a third flop; send_p = s2 & ~s3.
  - send_p is high exactly one cycle per rising edge.
  - First clk edge sampling enviar=1 → send_p high during the cycle after the second edge.
  - Holding enviar high produces no repeats.
- States: IDLE, RAMP, DONE.
- IDLE:
  - send_p → target <= ref_in (clamped per option).
  - If the new target equals ref_cur → go to DONE.
  - Otherwise → go to RAMP; tick counter cleared.
- RAMP:
  - busy=1.
  - Tick counter runs 0..TICK_DIV-1 and wraps; a tick fires when counter==TICK_DIV-1 and hold=0.
  - On tick, if |target−ref_cur| ≤ STEP: ref_cur <= target, next state DONE.
  - On tick otherwise: ref_cur <= ref_cur ± STEP, direction toward target.
  - Difference computed 9-bit unsigned. Never overshoot, never wrap past 0/255.
  - hold=1 freezes both the counter and ref_cur; busy stays 1.
  - send_p in RAMP retargets: target updated at the same edge, ramp continues from the present ref_cur, tick counter not reset.
  - If the retarget value equals ref_cur → DONE next cycle.
  - send_p coinciding with a tick: the tick uses the old target, and target takes the new value at the same edge.
- DONE:
  - Lasts one cycle; done=1, busy=0, then returns to IDLE.
  - send_p during DONE is processed as in IDLE on the following cycle; the request is not lost (register it for one cycle).
- TICK_DIV=1: one step per clock while in RAMP.
- ref_out is purely combinational from the ref_cur register. All other outputs are registered.

Optional Feature:
- Macro: REF_CLAMP_EN.
- Defined: the latched target is min(max(ref_in, REF_MIN), REF_MAX), clamped at the latch edge.
- Undefined: target = ref_in unmodified; REF_MIN/REF_MAX are ignored; no clamp logic is synthesized.

Test Plan:
- Reset: drive rst=0 with arbitrary inputs → ref_out=20'h0, target=0, busy=0, done=0. Asserting rst=0 mid-ramp → all return to 0 asynchronously.
- Basic ramp (TICK_DIV=4, STEP=1): ref_in=5, enviar 0→1 held 100 cycles → exactly one send. busy high; ref_cur = 1,2,3,4,5 at 4-cycle spacing. One done pulse; busy low afterwards.
- No overshoot (TICK_DIV=2, STEP=3): 0→10 → ref_cur sequence 3,6,9,10, then done.
- Retarget: ramp 0→20 (STEP=1); at ref_cur=8 set ref_in=4 and send → ref_cur 7,6,5,4, single done. Separately, send with ref_in=ref_cur → done with no ramp.
- Hold: assert hold for 10 cycles mid-ramp → ref_cur and tick count frozen. On release, resumes with the remaining tick count. done timing extends by 10 cycles.
- Clamp: REF_CLAMP_EN defined, REF_MAX=180, ref_in=250 → target=180, ramp ends at 180. Macro undefined → target=250.
